// File: rtl/sym_fir_filter_pipe.sv
`timescale 1ns/1ps
// Pipelined symmetric FIR: pre-add pairs, multiply, accumulate, then round/saturate.
// Four register stages with a valid bit riding alongside; clear flushes history and valids.
module sym_fir_filter_pipe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned COEFF_W    = 16,
    parameter int unsigned N_TAPS     = 11,
    parameter logic [((N_TAPS+1)/2)*COEFF_W-1:0] COEFFS = '0,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FRAC_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     valid_in,
    output logic signed [OUT_W-1:0]  data_out,
    output logic                     valid_out,
    output logic                     sat_out
);
    localparam int unsigned N_UNIQ  = (N_TAPS + 1) / 2;
    localparam int unsigned N_PAIR  = N_TAPS / 2;
    localparam int unsigned PRE_W   = DATA_W + 1;
    localparam int unsigned PROD_W  = PRE_W + COEFF_W;
    localparam int unsigned ACC_W   = PROD_W + $clog2(N_UNIQ);
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned CMP_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int unsigned RND_POS = (FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1;

    localparam logic signed [SUM_W-1:0] RND =
        (FRAC_SHIFT == 0) ? '0 : (SUM_W'(1) << RND_POS);
    localparam logic signed [CMP_W-1:0] OUT_MAX =
        {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] OUT_MIN =
        {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [DATA_W-1:0] dly    [N_TAPS-1];
    logic signed [DATA_W-1:0] x      [N_TAPS];
    logic signed [PRE_W-1:0]  pre_d  [N_UNIQ];
    logic signed [PRE_W-1:0]  pre_q  [N_UNIQ];
    logic signed [PROD_W-1:0] prod_d [N_UNIQ];
    logic signed [PROD_W-1:0] prod_q [N_UNIQ];
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [SUM_W-1:0]  sum_rnd;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [CMP_W-1:0]  cmp;
    logic signed [OUT_W-1:0]  out_d;
    logic                     sat_d;
    logic                     v1, v2, v3;

    // Tap view: x[0] is the incoming sample, x[j] the pre-shift delay line.
    always_comb begin
        x[0] = data_in;
        for (int j = 1; j < N_TAPS; j++) begin
            x[j] = dly[j-1];
        end
    end

    // Pre-add symmetric pairs; the odd-length centre tap passes through alone.
    always_comb begin
        pre_d = '{default: '0};
        for (int k = 0; k < N_PAIR; k++) begin
            pre_d[k] = PRE_W'(x[k]) + PRE_W'(x[N_TAPS-1-k]);
        end
        if (N_TAPS % 2 == 1) begin
            pre_d[N_UNIQ-1] = PRE_W'(x[N_PAIR]);
        end
    end

    always_comb begin
        for (int k = 0; k < N_UNIQ; k++) begin
            prod_d[k] = PROD_W'(pre_q[k]) * PROD_W'($signed(COEFFS[k*COEFF_W +: COEFF_W]));
        end
    end

    always_comb begin
        acc_d = '0;
        for (int k = 0; k < N_UNIQ; k++) begin
            acc_d = acc_d + ACC_W'(prod_q[k]);
        end
    end

    // Round half up, then clamp to the output range.
    always_comb begin
        sum_rnd = SUM_W'(acc_q) + RND;
        shifted = sum_rnd >>> FRAC_SHIFT;
        cmp     = CMP_W'(shifted);
        sat_d   = 1'b0;
        out_d   = OUT_W'(cmp);
        if (cmp > OUT_MAX) begin
            out_d = OUT_W'(OUT_MAX);
            sat_d = 1'b1;
        end else if (cmp < OUT_MIN) begin
            out_d = OUT_W'(OUT_MIN);
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int j = 0; j < N_TAPS - 1; j++) dly[j] <= '0;
            for (int k = 0; k < N_UNIQ; k++) begin
                pre_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            acc_q     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            sat_out   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            if (clear) begin
                for (int j = 0; j < N_TAPS - 1; j++) dly[j] <= '0;
                v1        <= 1'b0;
                v2        <= 1'b0;
                v3        <= 1'b0;
                valid_out <= 1'b0;
            end else begin
                if (valid_in) begin
                    dly[0] <= data_in;
                    for (int j = 1; j < N_TAPS - 1; j++) dly[j] <= dly[j-1];
                end
                v1        <= valid_in;
                v2        <= v1;
                v3        <= v2;
                valid_out <= v3;
                if (v3) begin
                    data_out <= out_d;
                    sat_out  <= sat_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_sym_fir_filter_pipe.sv
`timescale 1ns/1ps
// Bench for sym_fir_filter_pipe: five configurations on shared stimulus, table vectors,
// hand sequences for clear/reset, and a random run against a direct-form FIR model.
module tb_sym_fir_filter_pipe;
    typedef struct { int din; int exp_data; bit exp_sat; } vec_t;
    typedef struct { longint data; bit sat; int t; } obs_t;

    localparam logic [95:0] E_COEFFS = {16'sd20000, -16'sd12000, 16'sd8000,
                                        -16'sd3000, 16'sd1000, 16'sd500};
    int e_h[6] = '{500, 1000, -3000, 8000, -12000, 20000};

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    logic clear = 1'b0;
    logic valid_in = 1'b0;
    logic signed [15:0] data_in = '0;

    logic signed [23:0] a_data;
    logic signed [15:0] b_data, c_data, d_data, e_data;
    logic a_valid, b_valid, c_valid, d_valid, e_valid;
    logic a_sat, b_sat, c_sat, d_sat, e_sat;

    int cyc = 0;
    int sel = 0;
    int n_chk = 0;
    int n_fail = 0;
    longint obs_data;
    logic obs_valid, obs_sat;
    obs_t obs_q[$];
    obs_t exp_q[$];
    longint hist[$];
    vec_t tbl[$];
    int t_in[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sym_fir_filter_pipe #(.N_TAPS(5), .COEFFS(48'h0003_0002_0001), .OUT_W(24), .FRAC_SHIFT(0))
        u_a (.clk(clk), .arst_n(arst_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
             .data_out(a_data), .valid_out(a_valid), .sat_out(a_sat));
    sym_fir_filter_pipe #(.N_TAPS(4), .COEFFS(32'h0002_0001), .OUT_W(16), .FRAC_SHIFT(0))
        u_b (.clk(clk), .arst_n(arst_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
             .data_out(b_data), .valid_out(b_valid), .sat_out(b_sat));
    sym_fir_filter_pipe #(.N_TAPS(3), .COEFFS(32'h0000_0001), .OUT_W(16), .FRAC_SHIFT(1))
        u_c (.clk(clk), .arst_n(arst_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
             .data_out(c_data), .valid_out(c_valid), .sat_out(c_sat));
    sym_fir_filter_pipe #(.N_TAPS(4), .COEFFS(32'h0001_0001), .OUT_W(16), .FRAC_SHIFT(0))
        u_d (.clk(clk), .arst_n(arst_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
             .data_out(d_data), .valid_out(d_valid), .sat_out(d_sat));
    sym_fir_filter_pipe #(.N_TAPS(11), .COEFFS(E_COEFFS), .OUT_W(16), .FRAC_SHIFT(15))
        u_e (.clk(clk), .arst_n(arst_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
             .data_out(e_data), .valid_out(e_valid), .sat_out(e_sat));

    always_comb begin
        obs_valid = 1'b0;
        obs_data  = 0;
        obs_sat   = 1'b0;
        case (sel)
            0: begin obs_valid = a_valid; obs_data = longint'(a_data); obs_sat = a_sat; end
            1: begin obs_valid = b_valid; obs_data = longint'(b_data); obs_sat = b_sat; end
            2: begin obs_valid = c_valid; obs_data = longint'(c_data); obs_sat = c_sat; end
            3: begin obs_valid = d_valid; obs_data = longint'(d_data); obs_sat = d_sat; end
            default: begin obs_valid = e_valid; obs_data = longint'(e_data); obs_sat = e_sat; end
        endcase
    end

    always @(negedge clk) begin
        if (obs_valid === 1'b1) obs_q.push_back('{obs_data, obs_sat, cyc});
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int d, input bit c);
        @(posedge clk);
        #1;
        valid_in = v;
        data_in  = 16'(d);
        clear    = c;
    endtask

    task automatic add(input int d, input int e, input bit s);
        tbl.push_back('{d, e, s});
    endtask

    // Feed the table as valid samples (every gap cycles); expect each output 4 cycles later.
    task automatic run_table(input string tag, input int s, input int gap, input bit do_clr);
        int n;
        sel = s;
        if (do_clr) drive(0, 0, 1);
        drive(0, 0, 0);
        obs_q.delete();
        t_in.delete();
        foreach (tbl[i]) begin
            drive(1, tbl[i].din, 0);
            t_in.push_back(cyc);
            repeat (gap - 1) drive(0, 0, 0);
        end
        repeat (8) drive(0, 0, 0);
        chk({tag, " count"}, obs_q.size(), tbl.size());
        n = (obs_q.size() < tbl.size()) ? obs_q.size() : tbl.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] data", tag, i), obs_q[i].data, tbl[i].exp_data);
            chk($sformatf("%s[%0d] sat", tag, i), obs_q[i].sat, tbl[i].exp_sat);
            chk($sformatf("%s[%0d] time", tag, i), obs_q[i].t, t_in[i] + 4);
        end
    endtask

    // Direct-form reference: y = sum_j h_full[j] * x[n-j], then round half up and clamp.
    function automatic obs_t model_e(input int t);
        longint s = 0;
        longint r;
        obs_t o;
        for (int j = 0; j < 11; j++) begin
            if (j < hist.size()) s += hist[j] * longint'(e_h[(j <= 5) ? j : 10 - j]);
        end
        r = (s + 64'sd16384) >>> 15;
        o.sat = 1'b0;
        if (r > 32767) begin r = 32767; o.sat = 1'b1; end
        else if (r < -32768) begin r = -32768; o.sat = 1'b1; end
        o.data = r;
        o.t = t + 4;
        return o;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t0, n;
        bit v, c;
        int d;
        #1 arst_n = 1'b0;
        #20;
        chk("reset a_data", a_data, 0);
        chk("reset a_valid", a_valid, 0);
        chk("reset a_sat", a_sat, 0);
        chk("reset e_data", e_data, 0);
        chk("reset e_valid", e_valid, 0);
        chk("reset d_sat", d_sat, 0);
        @(negedge clk) arst_n = 1'b1;

        tbl.delete();
        add(1, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 2, 0); add(0, 1, 0); add(0, 0, 0);
        run_table("odd_impulse", 0, 1, 1);
        run_table("odd_gapped", 0, 3, 1);

        tbl.delete();
        add(1, 1, 0); add(0, 2, 0); add(0, 2, 0); add(0, 1, 0); add(0, 0, 0);
        run_table("even_impulse", 1, 1, 1);

        tbl.delete();
        add(3, 2, 0); add(-3, -1, 0); add(2, 3, 0); add(-2, -2, 0); add(0, 1, 0);
        run_table("round", 2, 1, 1);

        tbl.delete();
        add(32767, 32767, 0);
        for (int i = 0; i < 4; i++) add(32767, 32767, 1);
        run_table("sat_pos", 3, 1, 1);
        tbl.delete();
        add(-32768, -32768, 0);
        for (int i = 0; i < 4; i++) add(-32768, -32768, 1);
        run_table("sat_neg", 3, 1, 1);

        // Clear with valid_in during the impulse tail: remaining outputs and that sample vanish.
        sel = 0;
        drive(0, 0, 1);
        drive(0, 0, 0);
        obs_q.delete();
        drive(1, 1, 0);
        t0 = cyc;
        repeat (4) drive(1, 0, 0);
        drive(1, 5, 1);
        repeat (8) drive(0, 0, 0);
        chk("clear count", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk("clear[0] data", obs_q[0].data, 1);
            chk("clear[0] time", obs_q[0].t, t0 + 4);
            chk("clear[1] data", obs_q[1].data, 2);
        end
        tbl.delete();
        add(1, 1, 0); add(0, 2, 0); add(0, 3, 0); add(0, 2, 0); add(0, 1, 0); add(0, 0, 0);
        run_table("after_clear", 0, 1, 0);

        // Asynchronous reset mid-stream.
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(1, 1, 0);
        repeat (4) drive(1, 0, 0);
        #2;
        chk("pre_reset a_data", a_data, 1);
        chk("pre_reset a_valid", a_valid, 1);
        arst_n = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        #1;
        chk("mid_reset a_data", a_data, 0);
        chk("mid_reset a_valid", a_valid, 0);
        chk("mid_reset a_sat", a_sat, 0);
        #2 arst_n = 1'b1;
        obs_q.delete();
        repeat (8) drive(0, 0, 0);
        chk("post_reset count", obs_q.size(), 0);
        run_table("after_reset", 0, 1, 0);

        // Random stream with gaps and occasional clears on the 11-tap configuration.
        sel = 4;
        drive(0, 0, 1);
        drive(0, 0, 0);
        obs_q.delete();
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 7))
                0: d = 32767;
                1: d = -32768;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            drive(v, d, c);
            if (c) begin
                hist.delete();
                while (exp_q.size() > 0 && exp_q[$].t > cyc) void'(exp_q.pop_back());
            end else if (v) begin
                hist.push_front(longint'(d));
                if (hist.size() > 11) void'(hist.pop_back());
                exp_q.push_back(model_e(cyc));
            end
        end
        repeat (8) drive(0, 0, 0);
        chk("rand count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rand[%0d] data", i), obs_q[i].data, exp_q[i].data);
            chk($sformatf("rand[%0d] sat", i), obs_q[i].sat, exp_q[i].sat);
            chk($sformatf("rand[%0d] time", i), obs_q[i].t, exp_q[i].t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
